mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DEPTH, 13, number of 32-bit words in the attached data_memory; valid word addresses are 0..DEPTH-1.
- CNT_W, 16, width of the statistics counters.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clock_in  in  1  single clock; all flops are rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  word address.
- req_wdata  in  32  store data.
- req_tag  in  5  destination register tag, returned with the response.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline accepts the response.
- resp_data  out  32  load data; 0 for stores and errors.
- resp_tag  out  5  tag of the completed request.
- resp_write  out  1  completed request was a store.
- resp_err  out  1  address was out of range.
- memRead  out  1  read strobe to data_memory.
- memWrite  out  1  write strobe to data_memory.
- address  out  32  word address to data_memory.
- writeData  out  32  store data to data_memory.
- readData  in  32  read data from data_memory.
- load_count  out  CNT_W  completed loads.
- store_count  out  CNT_W  completed stores.
- err_count  out  CNT_W  rejected accesses.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 A request SHALL be accepted on the rising edge where req_valid and req_ready are both 1.
- On acceptance, req_write, req_addr, req_wdata and req_tag SHALL be latched.
REQ-006 On acceptance with req_addr < DEPTH, the next state SHALL be ACCESS.
REQ-007 On acceptance with req_addr >= DEPTH, the next state SHALL be RESP with resp_err=1, and no memory strobe SHALL be issued.
- The comparison is unsigned, full 32-bit.
REQ-008 In ACCESS, the block SHALL drive memRead=~write or memWrite=write for exactly one full clock cycle, registered.
- address and writeData SHALL be driven from the latched values.
- The strobe SHALL span the falling edge on which data_memory commits the write.
REQ-009 Outside ACCESS, memRead and memWrite SHALL be 0.
- address and writeData SHALL hold their last values; they are 0 after reset.
REQ-010 For a load, readData SHALL be captured into resp_data on the rising edge that ends ACCESS.
REQ-011 For a store, resp_data SHALL be 0.
REQ-012 After ACCESS, the next state SHALL be RESP.
REQ-013 In RESP, resp_valid SHALL be 1.
- resp_data, resp_tag, resp_write and resp_err SHALL remain stable until the handshake edge (resp_valid & resp_ready).
- On that edge, the next state SHALL be IDLE.
REQ-014 Latency SHALL be as follows, for acceptance at edge N:
- In-range request: strobe during cycle N..N+1; resp_valid from edge N+2.
- Out-of-range request: resp_valid from edge N+1.
REQ-015 Throughput: with resp_ready held at 1, back-to-back in-range requests SHALL complete one per 3 cycles.
REQ-016 A request offered while req_ready=0 SHALL be ignored (not latched); the requester holds it.
REQ-017 Statistics counters SHALL update on the response handshake edge only:
- load_count for loads without error;
- store_count for stores without error;
- err_count for any request with resp_err.
- Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-018 Holding resp_ready=0 indefinitely SHALL hold RESP with no change to outputs or counters.

Reset
REQ-019 Reset SHALL be asynchronous and SHALL immediately:
- force state IDLE;
- clear memRead, memWrite, address, writeData, resp_valid, resp_data, resp_tag, resp_write and resp_err to 0;
- clear all counters to 0;
- set req_ready to 1.
REQ-020 Reset mid-ACCESS or mid-RESP SHALL discard the pending request.
- No response SHALL be produced and no counter SHALL increment.
- The memory strobe SHALL drop at reset assertion, not at the next clock.
REQ-021 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-022 Reset, then load addr 5, resp_ready=1 -> resp_valid at edge N+2, resp_data=5, resp_tag echoed, load_count=1 (memory initialises word i to i).
REQ-023 Store addr 3 data 0xDEADBEEF, then load addr 3 -> store response resp_write=1, resp_data=0; load returns 0xDEADBEEF; store_count=1, load_count=1.
REQ-024 Load addr 13, then addr 0xFFFFFFFF -> each gives resp_err=1, resp_data=0 at edge N+1; memRead/memWrite never asserted; err_count=2.
REQ-025 Load addr 7 with resp_ready=0 for 4 cycles -> resp_valid and resp_data=7 stable; req_ready=0; second req_valid ignored; completion follows resp_ready=1.
REQ-026 Assert reset during ACCESS of a store to addr 2 -> memWrite=0 immediately; no response; store_count=0; memory word 2 reads 2 afterwards.
REQ-027 Force load_count to 0xFFFE, then perform 3 loads -> load_count=0xFFFF and held.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one pipeline load/store at a time onto a word-addressed
// data_memory, range-checks the address and keeps saturating access statistics.
module mem_access_unit #(
    parameter int DEPTH = 13,
    parameter int CNT_W = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [4:0]       req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [4:0]       resp_tag,
    output logic             resp_write,
    output logic             resp_err,
    output logic             memRead,
    output logic             memWrite,
    output logic [31:0]      address,
    output logic [31:0]      writeData,
    input  logic [31:0]      readData,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [4:0]         tag_q, tag_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [CNT_W-1:0]   load_count_q, load_count_d;
    logic [CNT_W-1:0]   store_count_q, store_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               in_range;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign in_range = (req_addr < 32'(DEPTH));

    // NOTE: every _d gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        tag_d         = tag_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        err_count_d   = err_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    tag_d   = req_tag;
                    rdata_d = '0;
                    if (in_range) begin
                        // Memory-side address/data only move for accesses that really happen.
                        state_d     = ACCESS;
                        err_d       = 1'b0;
                        addr_d      = req_addr;
                        wdata_d     = req_wdata;
                        mem_read_d  = ~req_write;
                        mem_write_d = req_write;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = write_q ? '0 : readData;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    if (err_q)        err_count_d   = sat_inc(err_count_q);
                    else if (write_q) store_count_d = sat_inc(store_count_q);
                    else              load_count_d  = sat_inc(load_count_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            tag_q         <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            load_count_q  <= '0;
            store_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            tag_q         <= tag_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_data   = rdata_q;
    assign resp_tag    = tag_q;
    assign resp_write  = write_q;
    assign resp_err    = err_q;
    assign memRead     = mem_read_q;
    assign memWrite    = mem_write_q;
    assign address     = addr_q;
    assign writeData   = wdata_q;
    assign load_count  = load_count_q;
    assign store_count = store_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of requests plus hand-written stall, saturation
// and mid-access reset sequences; a scoreboard checks every response.
module tb_mem_access_unit;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid, resp_ready, resp_write, resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        memRead, memWrite;
    logic [31:0] address, writeData, readData;
    logic [15:0] load_count, store_count, err_count;

    mem_access_unit #(.DEPTH(13), .CNT_W(16)) dut (
        .clock_in(clock_in), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_write(resp_write), .resp_err(resp_err),
        .memRead(memRead), .memWrite(memWrite), .address(address),
        .writeData(writeData), .readData(readData),
        .load_count(load_count), .store_count(store_count), .err_count(err_count)
    );

    always #5 clock_in = ~clock_in;

    int cycle = 0;
    always @(posedge clock_in) cycle <= cycle + 1;

    // data_memory: commits writes on the falling edge, reads combinationally
    logic [31:0] mem [13];
    assign readData = (address < 32'd13) ? mem[address[3:0]] : 32'h0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        err;
        int          acc_edge;
        int          strobe_start;
    } exp_t;

    exp_t sb[$];
    logic [15:0] exp_load, exp_store, exp_err;
    int strobe_cnt = 0;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Monitor: memory model writes on negedge, then samples 2ns later
    initial begin
        logic        valid_prev;
        int          seen_edge;
        logic [31:0] hold_data;
        logic [6:0]  hold_meta;
        exp_t        e;
        valid_prev = 1'b0;
        seen_edge  = 0;
        hold_data  = '0;
        hold_meta  = '0;
        for (int i = 0; i < 13; i++) mem[i] = 32'(i);
        forever begin
            @(negedge clock_in);
            if (memWrite && address < 32'd13) mem[address[3:0]] = writeData;
            #2;
            if (memRead || memWrite) begin
                strobe_cnt++;
                if (sb.size() == 0) begin
                    check("stray strobe", 32'({memRead, memWrite}), 32'd0);
                end else begin
                    check("strobe kind", 32'({memRead, memWrite}), 32'({~sb[0].write, sb[0].write}));
                    check("strobe address", address, sb[0].addr);
                    if (sb[0].write) check("strobe writeData", writeData, sb[0].wdata);
                end
            end
            if (resp_valid) begin
                if (!valid_prev) begin
                    seen_edge = cycle + 1;
                    hold_data = resp_data;
                    hold_meta = {resp_tag, resp_write, resp_err};
                end else begin
                    check("resp_data stable", resp_data, hold_data);
                    check("resp meta stable", 32'({resp_tag, resp_write, resp_err}), 32'(hold_meta));
                end
                if (resp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected response", 32'(resp_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_data", resp_data, e.data);
                        check("resp_tag", 32'(resp_tag), 32'(e.tag));
                        check("resp_write", 32'(resp_write), 32'(e.write));
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("resp latency", 32'(seen_edge - e.acc_edge), e.err ? 32'd1 : 32'd2);
                        check("strobe cycles", 32'(strobe_cnt - e.strobe_start), e.err ? 32'd0 : 32'd1);
                        if (e.err)        exp_err   = sat16(exp_err);
                        else if (e.write) exp_store = sat16(exp_store);
                        else              exp_load  = sat16(exp_load);
                    end
                end
            end
            valid_prev = resp_valid;
        end
    end

    // Offer a request at a negedge once req_ready is seen; leaves req_valid high.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] t, input logic [31:0] ed, input logic ee,
                        input bit track, output int acc);
        int   n = 0;
        exp_t e;
        @(negedge clock_in);
        while (!req_ready && n < 50) begin
            @(negedge clock_in);
            n++;
        end
        check("req_ready before offer", 32'(req_ready), 32'd1);
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_tag   = t;
        req_valid = 1'b1;
        @(posedge clock_in);
        #1;
        acc = cycle;
        if (track) begin
            e = '{w, a, wd, t, ed, ee, acc, strobe_cnt};
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock_in);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clock_in);
        #1;
    endtask

    task automatic check_counters(input string tagname);
        check({tagname, " load_count"}, 32'(load_count), 32'(exp_load));
        check({tagname, " store_count"}, 32'(store_count), 32'(exp_store));
        check({tagname, " err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int acc, prev_acc, rel_edge;
        vecs[0] = '{1'b0, 32'd5,         32'h0,        5'd1, 32'd5,        1'b0};
        vecs[1] = '{1'b1, 32'd3,         32'hDEADBEEF, 5'd2, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 32'd3,         32'h0,        5'd3, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 32'd13,        32'h0,        5'd4, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'h0,        5'd5, 32'h0,        1'b1};
        vecs[5] = '{1'b0, 32'd0,         32'h0,        5'd6, 32'd0,        1'b0};
        vecs[6] = '{1'b1, 32'd12,        32'h12345678, 5'd7, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 32'd12,        32'h0,        5'd8, 32'h12345678, 1'b0};
        vecs[8] = '{1'b1, 32'd20,        32'h0000AAAA, 5'd9, 32'h0,        1'b1};

        exp_load = '0; exp_store = '0; exp_err = '0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_tag = '0; resp_ready = 1'b1;

        @(posedge clock_in);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset strobes", 32'({memRead, memWrite}), 32'd0);
        check("reset address", address, 32'd0);
        check("reset writeData", writeData, 32'd0);
        check("reset resp fields", 32'({resp_data != 0, resp_tag, resp_write, resp_err}), 32'd0);
        check_counters("reset");

        @(posedge clock_in);
        #1;
        reset = 1'b0;
        rel_edge = cycle;

        // Table, back-to-back with req_valid held high
        prev_acc = 0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].tag,
                 vecs[i].exp_data, vecs[i].exp_err, 1'b1, acc);
            if (i == 0) begin
                check("first accept edge", 32'(acc - rel_edge), 32'd1);
                check("req_ready after accept", 32'(req_ready), 32'd0);
            end else begin
                check("accept spacing", 32'(acc - prev_acc), vecs[i-1].exp_err ? 32'd2 : 32'd3);
            end
            prev_acc = acc;
        end
        req_valid = 1'b0;
        drain();
        check_counters("table");
        check("address held after error", address, 32'd12);

        // Response stall with a second request offered meanwhile
        resp_ready = 1'b0;
        send(1'b0, 32'd7, 32'h0, 5'd10, 32'd7, 1'b0, 1'b1, acc);
        req_valid = 1'b0;
        begin
            int n = 0;
            while (!resp_valid && n < 10) begin
                @(negedge clock_in);
                n++;
            end
        end
        check("stall resp_valid", 32'(resp_valid), 32'd1);
        repeat (4) begin
            @(negedge clock_in);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd9; req_tag = 5'd11;
            #1;
            check("stall req_ready", 32'(req_ready), 32'd0);
            check("stall resp_data", resp_data, 32'd7);
            check("stall load_count", 32'(load_count), 32'(exp_load));
        end
        @(negedge clock_in);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain();
        @(negedge clock_in);
        check("post stall resp_valid", 32'(resp_valid), 32'd0);
        check("post stall req_ready", 32'(req_ready), 32'd1);
        check_counters("stall");

        // Saturation of load_count
        force dut.load_count_q = 16'hFFFE;
        @(posedge clock_in);
        #1;
        release dut.load_count_q;
        exp_load = 16'hFFFE;
        check("forced load_count", 32'(load_count), 32'h0000FFFE);
        send(1'b0, 32'd1, 32'h0, 5'd20, 32'd1, 1'b0, 1'b1, acc);
        send(1'b0, 32'd4, 32'h0, 5'd21, 32'd4, 1'b0, 1'b1, acc);
        send(1'b0, 32'd6, 32'h0, 5'd22, 32'd6, 1'b0, 1'b1, acc);
        req_valid = 1'b0;
        drain();
        check("saturated load_count", 32'(load_count), 32'h0000FFFF);
        check_counters("saturate");

        // Reset in the middle of a store's ACCESS cycle
        send(1'b1, 32'd2, 32'hCAFEF00D, 5'd12, 32'h0, 1'b0, 1'b0, acc);
        req_valid = 1'b0;
        check("store strobe up", 32'(memWrite), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("reset drops memWrite", 32'(memWrite), 32'd0);
        check("reset drops resp_valid", 32'(resp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset clears address", address, 32'd0);
        exp_load = '0; exp_store = '0; exp_err = '0;
        check_counters("mid reset");
        @(posedge clock_in);
        #2;
        reset = 1'b0;
        send(1'b0, 32'd2, 32'h0, 5'd13, 32'd2, 1'b0, 1'b1, acc);
        req_valid = 1'b0;
        drain();
        check_counters("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: simulation time exceeded");
        $fatal(1);
    end

endmodule
